reg_bank: RTL and testbench

Parametrised, handshaked control/status register bank; the next generation of the team's two-register control block. Holds NUM_REGS registers of DATA_W bits, with per-register access type (RW, RO, W1C), byte strobes and an error response. Sits between the bus-side request agent and the datapath, exporting control fields and taking status and event inputs from hardware.

---
 rtl/reg_bank_pkg.sv | 34 +++
 rtl/reg_bank_wreg.sv | 54 +++++
 rtl/reg_bank.sv | 140 ++++++++++++++
 tb/tb_reg_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the control/status register bank.
package reg_bank_pkg;

  // Register map
  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_DEBUG  = 1;
  localparam int unsigned ADDR_STATUS = 2;
  localparam int unsigned ADDR_INTR   = 3;

  // CTRL field bit offsets
  localparam int unsigned CTRL_MODE_EN_BIT   = 0;
  localparam int unsigned CTRL_DBG_EN_BIT    = 1;
  localparam int unsigned CTRL_PARITY_EN_BIT = 2;
  localparam int unsigned CTRL_EN_LSB        = 3;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_e;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  // Access type of a register index; everything above INTR is RW scratch.
  function automatic acc_e acc_of(input int idx);
    if (idx == int'(ADDR_STATUS)) return ACC_RO;
    if (idx == int'(ADDR_INTR))   return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/reg_bank_wreg.sv
// One stored register with byte strobes; RW merges strobed bytes,
// W1C clears strobed bits written as 1 while set_bits always win.
module reg_bank_wreg
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter acc_e        ACC    = ACC_RW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   set_bits,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] byte_mask;

  // Expand byte strobes to a bit mask
  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      byte_mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  // Next value: byte merge for RW, clear-then-set for W1C
  always_comb begin
    q_d = q_q;
    if (ACC == ACC_W1C) begin
      if (wr_en) begin
        q_d = q_q & ~(wdata & byte_mask);
      end
      q_d = q_d | set_bits;
    end else if (wr_en) begin
      q_d = (q_q & ~byte_mask) | (wdata & byte_mask);
    end
  end

  // Storage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_bank.sv
// Handshaked control/status register bank: CTRL, DEBUG, STATUS (live),
// INTR (W1C with hardware set) and RW scratch registers.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic [DATA_W-1:0]   hw_status,
  input  logic [DATA_W-1:0]   hw_intr_set,
  output logic                ctrl_mode_en,
  output logic                ctrl_dbg_en,
  output logic                ctrl_parity_en,
  output logic [DATA_W-4:0]   ctrl_en,
  output logic [DATA_W-1:0]   debug_q,
  output logic                intr_pending
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_q;
  logic              rsp_err_d;
  logic              intr_pending_q;
  logic              intr_pending_d;

  logic [DATA_W-1:0] reg_val [NUM_REGS];
  logic [DATA_W-1:0] rd_val;
  logic              addr_hit;
  logic              is_status;
  logic              accept;
  logic              wr_legal;

  // Address decode and read mux; out-of-range indices give addr_hit = 0
  always_comb begin
    addr_hit = 1'b0;
    rd_val   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        addr_hit = 1'b1;
        rd_val   = reg_val[i];
      end
    end
    is_status = (req_addr == ADDR_W'(ADDR_STATUS));
    accept    = (state_q == S_IDLE) && req_valid;
    wr_legal  = accept && req_write && addr_hit && !is_status;
  end

  // STATUS is a live view of hw_status; every other index has storage
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    if (i == int'(ADDR_STATUS)) begin : g_status
      assign reg_val[i] = hw_status;
    end else begin : g_store
      logic              we;
      logic [DATA_W-1:0] set_bits;
      assign we       = wr_legal && (req_addr == ADDR_W'(i));
      assign set_bits = (i == int'(ADDR_INTR)) ? hw_intr_set : '0;
      reg_bank_wreg #(
        .DATA_W (DATA_W),
        .ACC    (acc_of(i))
      ) u_wreg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (we),
        .wdata    (req_wdata),
        .wstrb    (req_wstrb),
        .set_bits (set_bits),
        .q        (reg_val[i])
      );
    end
  end

  // FSM next state and response capture at the acceptance edge
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_RESP;
          rsp_err_d   = !addr_hit || (req_write && is_status);
          rsp_rdata_d = req_write ? '0 : rd_val;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt summary, one cycle behind INTR
  always_comb begin
    intr_pending_d = |reg_val[ADDR_INTR];
  end

  // State, response and summary registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      intr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      intr_pending_q <= intr_pending_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign intr_pending   = intr_pending_q;
  assign ctrl_mode_en   = reg_val[ADDR_CTRL][CTRL_MODE_EN_BIT];
  assign ctrl_dbg_en    = reg_val[ADDR_CTRL][CTRL_DBG_EN_BIT];
  assign ctrl_parity_en = reg_val[ADDR_CTRL][CTRL_PARITY_EN_BIT];
  assign ctrl_en        = reg_val[ADDR_CTRL][DATA_W-1:CTRL_EN_LSB];
  assign debug_q        = reg_val[ADDR_DEBUG];

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank with NUM_REGS=6 (indices 6 and 7 out of range).
module tb_reg_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 6;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [DW-1:0] hw_status;
  logic [DW-1:0] hw_intr_set;
  logic          ctrl_mode_en;
  logic          ctrl_dbg_en;
  logic          ctrl_parity_en;
  logic [DW-4:0] ctrl_en;
  logic [DW-1:0] debug_q;
  logic          intr_pending;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  reg_bank #(
    .DATA_W   (DW),
    .NUM_REGS (NR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wstrb      (req_wstrb),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .hw_status      (hw_status),
    .hw_intr_set    (hw_intr_set),
    .ctrl_mode_en   (ctrl_mode_en),
    .ctrl_dbg_en    (ctrl_dbg_en),
    .ctrl_parity_en (ctrl_parity_en),
    .ctrl_en        (ctrl_en),
    .debug_q        (debug_q),
    .intr_pending   (intr_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; returns captured response.
  task automatic xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
    int unsigned n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    rsp_ready = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    hw_intr_set = '0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1;
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    rsp_ready   = 1'b1;
    hw_status   = '0;
    hw_intr_set = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ctrl_en", 32'(ctrl_en), 32'd0);
    check("rst_debug_q", debug_q, 32'd0);
    check("rst_intr_pending", 32'(intr_pending), 32'd0);

    // CTRL write and readback
    xact(1'b1, 3'd0, 32'h0000_0005, 4'hF, rd, er);
    check("ctrl_wr_err", 32'(er), 32'd0);
    check("ctrl_wr_rdata", rd, 32'd0);
    check("ctrl_mode_en", 32'(ctrl_mode_en), 32'd1);
    check("ctrl_dbg_en", 32'(ctrl_dbg_en), 32'd0);
    check("ctrl_parity_en", 32'(ctrl_parity_en), 32'd1);
    check("ctrl_en", 32'(ctrl_en), 32'd0);
    xact(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
    check("ctrl_rd", rd, 32'h0000_0005);
    check("ctrl_rd_err", 32'(er), 32'd0);

    // DEBUG byte-strobe merge
    xact(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("debug_q_full", debug_q, 32'hFFFF_FFFF);
    xact(1'b1, 3'd1, 32'h1234_5678, 4'h2, rd, er);
    xact(1'b0, 3'd1, 32'h0, 4'h0, rd, er);
    check("debug_strb_rd", rd, 32'hFFFF_56FF);
    check("debug_q_strb", debug_q, 32'hFFFF_56FF);

    // INTR set pulse and registered summary
    @(negedge clk);
    hw_intr_set = 32'h9;
    @(posedge clk);
    #1;
    hw_intr_set = '0;
    check("intr_pend_lag", 32'(intr_pending), 32'd0);
    @(posedge clk);
    #1;
    check("intr_pend_set", 32'(intr_pending), 32'd1);
    xact(1'b1, 3'd3, 32'h1, 4'hF, rd, er);
    check("intr_w1c_err", 32'(er), 32'd0);
    xact(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("intr_after_w1c", rd, 32'h8);
    hw_intr_set = 32'h8;
    xact(1'b1, 3'd3, 32'h8, 4'hF, rd, er);
    xact(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("intr_set_wins", rd, 32'h8);
    xact(1'b1, 3'd3, 32'hFF, 4'h0, rd, er);
    check("intr_strb0_err", 32'(er), 32'd0);
    xact(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("intr_strb0_keep", rd, 32'h8);
    xact(1'b1, 3'd3, 32'h8, 4'h1, rd, er);
    xact(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("intr_cleared", rd, 32'h0);
    check("intr_pend_clr", 32'(intr_pending), 32'd0);

    // STATUS, scratch and out-of-range
    xact(1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF, rd, er);
    check("status_wr_err", 32'(er), 32'd1);
    check("status_wr_rdata", rd, 32'd0);
    hw_status = 32'hA5A5_0000;
    xact(1'b0, 3'd2, 32'h0, 4'h0, rd, er);
    check("status_rd", rd, 32'hA5A5_0000);
    check("status_rd_err", 32'(er), 32'd0);
    xact(1'b1, 3'd5, 32'hCAFE_F00D, 4'hF, rd, er);
    xact(1'b0, 3'd5, 32'h0, 4'h0, rd, er);
    check("scratch5_rd", rd, 32'hCAFE_F00D);
    xact(1'b0, 3'd7, 32'h0, 4'h0, rd, er);
    check("oor_rd_err", 32'(er), 32'd1);
    check("oor_rd_rdata", rd, 32'd0);
    xact(1'b1, 3'd6, 32'h1111_1111, 4'hF, rd, er);
    check("oor_wr_err", 32'(er), 32'd1);

    // Response held under backpressure, then reset mid-hold
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hFFFF_56FF);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_debug_q", debug_q, 32'd0);
    check("arst_ctrl_mode", 32'(ctrl_mode_en), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    hw_status = '0;
    xact(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
    check("post_rst_ctrl", rd, 32'd0);
    xact(1'b0, 3'd1, 32'h0, 4'h0, rd, er);
    check("post_rst_debug", rd, 32'd0);
    xact(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("post_rst_intr", rd, 32'd0);
    xact(1'b0, 3'd4, 32'h0, 4'h0, rd, er);
    check("post_rst_scr4", rd, 32'd0);
    xact(1'b0, 3'd5, 32'h0, 4'h0, rd, er);
    check("post_rst_scr5", rd, 32'd0);
    check("post_rst_pend", 32'(intr_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
